acia_tx_fifo: RTL and testbench

- Transmit-side buffer that sits directly upstream of the ACIA serial transmitter.
- Accepts bytes written by the CPU bus interface and stores them in a circular FIFO.
- Presents the head byte and a start request to the transmitter, popping one entry each time the transmitter accepts.
- Reports full, empty, level and sticky-overflow status back to the ACIA register file.

---
 rtl/acia_tx_fifo_if.sv | 31 +++
 rtl/acia_tx_fifo.sv | 82 ++++++++
 tb/tb_acia_tx_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/acia_tx_fifo_if.sv
// Bus/transmitter-facing signal bundle for the ACIA transmit FIFO.
// master drives writes and transmitter status, slave is the FIFO.
interface acia_tx_fifo_if #(
  parameter int AW = 4
);
  logic          pclk;
  logic          wr;
  logic [7:0]    wr_dat;
  logic          flush;
  logic          ovf_clr;
  logic          tx_busy;
  logic [7:0]    tx_dat;
  logic          tx_start;
  logic          full;
  logic          empty;
  logic          tx_low;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output pclk, wr, wr_dat, flush, ovf_clr, tx_busy,
    input  tx_dat, tx_start, full, empty, tx_low,
    input  count, overflow
  );

  modport slave (
    input  pclk, wr, wr_dat, flush, ovf_clr, tx_busy,
    output tx_dat, tx_start, full, empty, tx_low,
    output count, overflow
  );
endinterface

// File: rtl/acia_tx_fifo.sv
// ACIA transmit FIFO: circular byte buffer with show-ahead head
// presented to the serial transmitter, plus level/overflow status.
module acia_tx_fifo #(
  parameter int AW        = 4,
  parameter int LOW_WATER = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  acia_tx_fifo_if.slave   bus
);
  localparam int DEPTH = 2 ** AW;

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty;
  logic          pop, accept, ovf_set;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == (AW+1)'(DEPTH));
  end

  // flush blocks both pop and write in its cycle
  always_comb begin
    pop     = bus.pclk & ~bus.tx_busy & ~empty & ~bus.flush;
    accept  = bus.wr & (~full | pop) & ~bus.flush;
    ovf_set = bus.wr & full & ~pop & ~bus.flush;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      unique case ({accept, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (ovf_set)     ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= bus.wr_dat;
  end

  always_comb begin
    bus.tx_dat   = mem_q[rd_ptr_q];
    bus.tx_start = ~empty;
    bus.full     = full;
    bus.empty    = empty;
    bus.tx_low   = (count_q <= (AW+1)'(LOW_WATER));
    bus.count    = count_q;
    bus.overflow = ovf_q;
  end
endmodule

// File: tb/tb_acia_tx_fifo.sv
// Scoreboard bench for acia_tx_fifo: expected bytes queued at write,
// compared by a monitor at every transmitter pop.
module tb_acia_tx_fifo;
  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] sb[$];

  acia_tx_fifo_if #(.AW(4)) bus ();

  acia_tx_fifo #(.AW(4), .LOW_WATER(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input bit store);
    bus.wr     = 1'b1;
    bus.wr_dat = d;
    if (store) sb.push_back(d);
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic drain(input string n);
    int k;
    bus.pclk    = 1'b1;
    bus.tx_busy = 1'b0;
    k = 0;
    while (!bus.empty && k < 40) begin
      tick();
      k++;
    end
    chk(n, {31'd0, bus.empty}, 32'd1);
  endtask

  // monitor: a pop happens at the coming edge, compare the head byte
  always @(negedge clk) begin
    if (reset_n && bus.tx_start && bus.pclk &&
        !bus.tx_busy && !bus.flush) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none",
                 bus.tx_dat);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (bus.tx_dat !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h",
                   bus.tx_dat, e);
        end
      end
    end
  end

  initial begin
    int ec;
    reset_n     = 1'b0;
    bus.pclk    = 1'b1;
    bus.wr      = 1'b0;
    bus.wr_dat  = 8'h00;
    bus.flush   = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.tx_busy = 1'b0;
    #2;
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_count", {27'd0, bus.count}, 32'd0);
    chk("rst_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_low", {31'd0, bus.tx_low}, 32'd1);
    #15 reset_n = 1'b1;
    tick();

    // 1: single byte, 1-cycle latency then pop
    put(8'h41, 1'b1);
    chk("t1_start", {31'd0, bus.tx_start}, 32'd1);
    chk("t1_dat", {24'd0, bus.tx_dat}, 32'h41);
    chk("t1_count", {27'd0, bus.count}, 32'd1);
    tick();
    chk("t1_count0", {27'd0, bus.count}, 32'd0);
    chk("t1_empty", {31'd0, bus.empty}, 32'd1);

    // 2: fill while busy, overflow
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) put(8'(i), 1'b1);
    put(8'hAA, 1'b0);
    chk("t2_full", {31'd0, bus.full}, 32'd1);
    chk("t2_count", {27'd0, bus.count}, 32'd16);
    chk("t2_ovf", {31'd0, bus.overflow}, 32'd1);
    bus.ovf_clr = 1'b1;
    put(8'hBB, 1'b0);
    chk("t2_ovf_setwins", {31'd0, bus.overflow}, 32'd1);
    tick();
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", {31'd0, bus.overflow}, 32'd0);

    // 3: write into full FIFO during a pop
    bus.tx_busy = 1'b0;
    bus.wr      = 1'b1;
    bus.wr_dat  = 8'h55;
    sb.push_back(8'h55);
    tick();
    bus.wr      = 1'b0;
    bus.tx_busy = 1'b1;
    chk("t3_count", {27'd0, bus.count}, 32'd16);
    chk("t3_full", {31'd0, bus.full}, 32'd1);
    chk("t3_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("t3_head", {24'd0, bus.tx_dat}, 32'h01);
    drain("t3_drain");

    // 4: sparse pclk, one pop per enable
    bus.pclk = 1'b0;
    put(8'hB1, 1'b1);
    put(8'hB2, 1'b1);
    put(8'hB3, 1'b1);
    chk("t4_count", {27'd0, bus.count}, 32'd3);
    ec = 3;
    for (int i = 0; i < 12; i++) begin
      bus.pclk = (i % 4 == 3);
      tick();
      if (bus.pclk && ec > 0) ec--;
      chk("t4_cnt", {27'd0, bus.count}, 32'(ec));
      chk("t4_start", {31'd0, bus.tx_start}, {31'd0, ec != 0});
    end
    bus.pclk = 1'b0;

    // 5: flush beats write, overflow preserved
    for (int i = 0; i < 10; i++) put(8'hC0 + 8'(i), 1'b1);
    chk("t5_count", {27'd0, bus.count}, 32'd10);
    chk("t5_low", {31'd0, bus.tx_low}, 32'd0);
    bus.flush  = 1'b1;
    bus.wr     = 1'b1;
    bus.wr_dat = 8'h77;
    sb.delete();
    tick();
    bus.flush = 1'b0;
    bus.wr    = 1'b0;
    chk("t5_fcount", {27'd0, bus.count}, 32'd0);
    chk("t5_fempty", {31'd0, bus.empty}, 32'd1);
    chk("t5_fstart", {31'd0, bus.tx_start}, 32'd0);
    chk("t5_fovf", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 16; i++) put(8'hD0 + 8'(i), 1'b0);
    put(8'hE0, 1'b0);
    chk("t5_ovf", {31'd0, bus.overflow}, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t5_ovf_kept", {31'd0, bus.overflow}, 32'd1);
    chk("t5_count2", {27'd0, bus.count}, 32'd0);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t5_ovf_clr", {31'd0, bus.overflow}, 32'd0);
    put(8'h5A, 1'b1);
    chk("t5_post_head", {24'd0, bus.tx_dat}, 32'h5A);
    drain("t5_drain");

    // 6: async reset mid-cycle
    bus.pclk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(8'hF0 + 8'(i), 1'b1);
      chk("t6_low", {31'd0, bus.tx_low}, {31'd0, (i + 1) <= 4});
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_count", {27'd0, bus.count}, 32'd0);
    chk("t6_empty", {31'd0, bus.empty}, 32'd1);
    chk("t6_start", {31'd0, bus.tx_start}, 32'd0);
    chk("t6_low_rst", {31'd0, bus.tx_low}, 32'd1);
    #12 reset_n = 1'b1;
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
